// File: rtl/timer_port.sv
// Memory-mapped countdown timer with prescaler, one-shot/auto-reload modes and an irq output.
// Registers: LOAD, COUNT (read-only), CTRL, STATUS (write-1-to-clear).
module timer_port #(
    parameter logic [3:0] BASE     = 4'b0011,
    parameter int         PRESCALE = 4
) (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic [15:0] addr,
    input  logic [15:0] data_out,
    input  logic        write,
    output logic [15:0] din,
    output logic        hit,
    output logic        irq
);

    typedef enum logic [1:0] {IDLE, RUN, EXPIRED} state_e;

    localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

    state_e      state_q;
    logic [15:0] load_q, count_q, pre_q, din_q;
    logic        en_q, ar_q, ie_q, expired_q, hit_q;

    logic        sel, wr_load, wr_ctrl, wr_status, tick, expiry;
    logic [15:0] rd_data;
    logic        addr_unused;

    assign addr_unused = ^addr[11:2];

    always_comb begin
        sel       = (addr[15:12] == BASE);
        wr_load   = sel && write && (addr[1:0] == 2'd0);
        wr_ctrl   = sel && write && (addr[1:0] == 2'd2);
        wr_status = sel && write && (addr[1:0] == 2'd3);
        tick      = (state_q == RUN) && (pre_q == PRE_LAST);
        expiry    = tick && (count_q <= 16'd1);
    end

    always_comb begin
        rd_data = '0;  // NOTE: default assignment first so no path through the case infers a latch
        case (addr[1:0])
            2'd0:    rd_data = load_q;
            2'd1:    rd_data = count_q;
            2'd2:    rd_data = {13'd0, ie_q, ar_q, en_q};
            default: rd_data = {15'd0, expired_q};
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            load_q    <= '0;
            count_q   <= '0;
            pre_q     <= '0;
            din_q     <= '0;
            en_q      <= 1'b0;
            ar_q      <= 1'b0;
            ie_q      <= 1'b0;
            expired_q <= 1'b0;
            hit_q     <= 1'b0;
        end else begin
            hit_q <= sel;
            din_q <= (sel && !write) ? rd_data : '0;

            if (wr_load) load_q <= data_out;

            // An expiry sets the flag even if software clears it in the same cycle.
            if (expiry)                        expired_q <= 1'b1;
            else if (wr_status && data_out[0]) expired_q <= 1'b0;

            if (wr_ctrl) begin
                en_q  <= data_out[0];
                ar_q  <= data_out[1];
                ie_q  <= data_out[2];
                pre_q <= '0;
                if (data_out[0]) begin
                    state_q <= RUN;
                    count_q <= load_q;
                end else begin
                    state_q <= IDLE;
                end
            end else begin
                case (state_q)
                    RUN: begin
                        if (tick) begin
                            pre_q <= '0;
                            if (!expiry) begin
                                count_q <= count_q - 16'd1;
                            end else if (ar_q) begin
                                count_q <= load_q;
                            end else begin
                                count_q <= '0;
                                en_q    <= 1'b0;
                                state_q <= EXPIRED;
                            end
                        end else begin
                            pre_q <= pre_q + 16'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign din = din_q;
    assign hit = hit_q;
    assign irq = expired_q & ie_q;

endmodule

// File: tb/tb_timer_port.sv
// Scoreboard bench for timer_port: a tick-schedule reference model predicts din/hit/irq per cycle,
// a separate monitor compares on the falling edge.
module tb_timer_port;

    localparam logic [3:0] BASE = 4'b0011;
    localparam int         P    = 4;

    logic        Clock, Resetn, write;
    logic [15:0] addr, data_out, din;
    logic        hit, irq;

    timer_port #(.BASE(BASE), .PRESCALE(P)) dut (
        .Clock(Clock), .Resetn(Resetn), .addr(addr), .data_out(data_out),
        .write(write), .din(din), .hit(hit), .irq(irq)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [15:0] din;
        logic        hit;
        logic        irq;
        string       tag;
    } exp_t;

    exp_t  sb[$];
    int    vectors = 0;
    int    miscompares = 0;
    string phase = "reset";

    // Reference model: enable bit doubles as "running"; ticks land every P edges after the start edge.
    int          cyc = 0;
    int          m_start = 0;
    logic [15:0] m_load = 0, m_count = 0;
    logic        m_en = 0, m_ar = 0, m_ie = 0, m_exp = 0;

    task automatic check(input string name, input logic [17:0] act, input logic [17:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got din=%h hit=%b irq=%b, want din=%h hit=%b irq=%b",
                     name, act[17:2], act[1], act[0], expv[17:2], expv[1], expv[0]);
        end
    endtask

    task automatic model_reset();
        m_load = 0; m_count = 0; m_en = 0; m_ar = 0; m_ie = 0; m_exp = 0;
    endtask

    task automatic cycle(input logic [15:0] a, input logic [15:0] d, input logic w);
        exp_t        e;
        logic        sel, tick, expiry;
        logic [15:0] rdv, old_load, old_count;
        @(negedge Clock);
        #1;
        addr = a; data_out = d; write = w;
        cyc++;
        sel = (a[15:12] == BASE);
        case (a[1:0])
            2'd0:    rdv = m_load;
            2'd1:    rdv = m_count;
            2'd2:    rdv = {13'd0, m_ie, m_ar, m_en};
            default: rdv = {15'd0, m_exp};
        endcase
        e.din = (sel && !w) ? rdv : 16'd0;
        e.hit = sel;
        tick   = m_en && (cyc > m_start) && ((cyc - m_start) % P == 0);
        expiry = tick && (m_count <= 16'd1);
        old_load  = m_load;
        old_count = m_count;
        if (tick) begin
            if (expiry) begin
                m_exp = 1;
                if (m_ar) m_count = old_load;
                else begin m_count = 0; m_en = 0; end
            end else begin
                m_count = m_count - 16'd1;
            end
        end
        if (sel && w) begin
            case (a[1:0])
                2'd0: m_load = d;
                2'd2: begin
                    m_en = d[0]; m_ar = d[1]; m_ie = d[2];
                    if (d[0]) begin m_count = old_load; m_start = cyc; end
                    else m_count = old_count;
                end
                2'd3: if (d[0] && !expiry) m_exp = 0;
                default: ;
            endcase
        end
        e.irq = m_exp && m_ie;
        e.tag = phase;
        sb.push_back(e);
    endtask

    function automatic logic [15:0] reg_addr(input logic [1:0] r);
        return {BASE, 10'd0, r};
    endfunction

    task automatic idle(input int n, input logic [1:0] r);
        for (int i = 0; i < n; i++) cycle(reg_addr(r), 16'h0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clock);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.tag, {din, hit, irq}, {e.din, e.hit, e.irq});
            end
        end
    end

    initial begin : stim
        Resetn = 1'b0; addr = '0; data_out = '0; write = 1'b0;
        #1;
        check("reset_outputs", {din, hit, irq}, 18'd0);
        #20;
        @(negedge Clock);
        #1 Resetn = 1'b1;

        phase = "post_reset_regs";
        for (int r = 0; r < 4; r++) cycle(reg_addr(2'(r)), 16'h0, 1'b0);

        phase = "read_timing";
        cycle(reg_addr(0), 16'h1234, 1'b1);
        cycle(16'h3000, 16'h0, 1'b0);
        cycle(16'h1000, 16'h0, 1'b0);
        cycle(16'h3000, 16'h0, 1'b1);

        phase = "one_shot";
        cycle(reg_addr(0), 16'd3, 1'b1);
        cycle(reg_addr(2), 16'd1, 1'b1);
        idle(13, 2'd1);
        cycle(reg_addr(3), 16'h0, 1'b0);
        cycle(reg_addr(2), 16'h0, 1'b0);
        cycle(reg_addr(1), 16'h0, 1'b0);

        phase = "auto_reload_irq";
        cycle(reg_addr(3), 16'h1, 1'b1);
        cycle(reg_addr(0), 16'd2, 1'b1);
        cycle(reg_addr(2), 16'd7, 1'b1);
        idle(20, 2'd1);
        cycle(reg_addr(3), 16'h1, 1'b1);
        idle(6, 2'd1);
        cycle(reg_addr(2), 16'h0, 1'b1);

        phase = "collide_status_clear";
        cycle(reg_addr(3), 16'h1, 1'b1);
        cycle(reg_addr(0), 16'd2, 1'b1);
        cycle(reg_addr(2), 16'd1, 1'b1);
        idle(7, 2'd1);
        cycle(reg_addr(3), 16'h1, 1'b1);
        cycle(reg_addr(3), 16'h0, 1'b0);

        phase = "collide_ctrl_stop";
        cycle(reg_addr(3), 16'h1, 1'b1);
        cycle(reg_addr(2), 16'd1, 1'b1);
        idle(7, 2'd1);
        cycle(reg_addr(2), 16'h0, 1'b1);
        idle(10, 2'd1);
        cycle(reg_addr(3), 16'h0, 1'b0);

        phase = "edge_load_zero";
        cycle(reg_addr(0), 16'd0, 1'b1);
        cycle(reg_addr(2), 16'd1, 1'b1);
        idle(6, 2'd1);
        cycle(reg_addr(3), 16'h0, 1'b0);

        phase = "edge_load_ffff";
        cycle(reg_addr(0), 16'hFFFF, 1'b1);
        cycle(reg_addr(2), 16'd1, 1'b1);
        idle(10, 2'd1);
        cycle(reg_addr(1), 16'h0042, 1'b1);
        idle(3, 2'd1);
        cycle(16'h7001, 16'h0005, 1'b1);
        cycle(16'h5002, 16'h0000, 1'b1);
        idle(4, 2'd1);

        phase = "random";
        for (int i = 0; i < 1500; i++) begin
            int          r;
            logic [3:0]  nb;
            logic [15:0] d;
            r  = $urandom_range(0, 99);
            nb = 4'(BASE + 4'(1 + $urandom_range(0, 14)));
            if (r < 30)
                cycle({BASE, 10'($urandom), 2'($urandom)}, 16'($urandom), 1'b0);
            else if (r < 42)
                cycle({nb, 10'($urandom), 2'($urandom)}, 16'($urandom), 1'b0);
            else if (r < 55) begin
                d = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom_range(0, 6));
                cycle(reg_addr(0), d, 1'b1);
            end else if (r < 68) begin
                d = 16'($urandom);
                d[0] = ($urandom_range(0, 3) != 0);
                cycle(reg_addr(2), d, 1'b1);
            end else if (r < 78)
                cycle(reg_addr(3), 16'($urandom), 1'b1);
            else if (r < 83)
                cycle(reg_addr(1), 16'($urandom), 1'b1);
            else if (r < 90)
                cycle({nb, 10'($urandom), 2'($urandom)}, 16'($urandom), 1'b1);
            else
                cycle({BASE, 12'($urandom)}, 16'($urandom), 1'b0);
        end

        phase = "reset_mid_run";
        cycle(reg_addr(3), 16'h1, 1'b1);
        cycle(reg_addr(0), 16'd1, 1'b1);
        cycle(reg_addr(2), 16'd4, 1'b1);
        cycle(reg_addr(2), 16'd5, 1'b1);
        idle(6, 2'd3);
        cycle(reg_addr(0), 16'd100, 1'b1);
        cycle(reg_addr(2), 16'd7, 1'b1);
        idle(3, 2'd0);
        @(negedge Clock);
        #2 Resetn = 1'b0;
        #1 check("reset_async_outputs", {din, hit, irq}, 18'd0);
        model_reset();
        #15 Resetn = 1'b1;
        phase = "after_reset_idle";
        idle(120, 2'd1);
        cycle(reg_addr(2), 16'h0, 1'b0);
        cycle(reg_addr(3), 16'h0, 1'b0);
        cycle(reg_addr(0), 16'h0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge Clock);
        #1;
        if (sb.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: %0d expected responses left unchecked, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/timer_port.md
TIMER_PORT -- requirements
Module: timer_port

Interface
REQ-001 Parameter BASE, default 4'b0011, SHALL give the addr[15:12] value that selects this block.
REQ-002 Parameter PRESCALE, default 4, SHALL give the number of Clock cycles per timer tick (legal range 1..65535).
REQ-003 Clock  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 Resetn  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 addr  input  16  SHALL be the processor address register value; [15:12] selects the block, [1:0] selects the register.
REQ-006 data_out  input  16  SHALL be the processor write data.
REQ-007 write  input  1  SHALL be the processor write strobe, high for exactly the cycle a store is presented.
REQ-008 din  output  16  SHALL be the registered read data returned to the processor.
REQ-009 hit  output  1  SHALL be registered and high the cycle after addr[15:12]==BASE, for external read muxing.
REQ-010 irq  output  1  SHALL be combinational: STATUS.expired AND CTRL.irq_en.

Function
REQ-011 sel SHALL equal (addr[15:12]==BASE); a write occurs in any cycle where sel & write.
REQ-012 Register map by addr[1:0] SHALL be: 0 LOAD (R/W, 16 bits); 1 COUNT (R only, writes ignored); 2 CTRL (R/W; bit0 enable, bit1 auto_reload, bit2 irq_en, bits[15:3] read 0); 3 STATUS (bit0 expired; write-1-to-clear; bits[15:1] read 0).
REQ-013 Read latency SHALL be 1 cycle: din <= selected register when sel & ~write, else din <= 0, matching a synchronous RAM.
REQ-014 The FSM SHALL have states IDLE, RUN and EXPIRED.
REQ-015 In IDLE, COUNT SHALL hold. A CTRL write with bit0=1 SHALL cause a transition to RUN, set COUNT <= LOAD, and clear the prescaler.
REQ-016 The prescaler SHALL count 0..PRESCALE-1 only in RUN. A tick SHALL occur in the cycle the prescaler equals PRESCALE-1, and the prescaler SHALL then wrap to 0.
REQ-017 In RUN, a tick with COUNT>1 SHALL decrement COUNT by 1. A tick with COUNT<=1 is an expiry (LOAD=0 therefore behaves as LOAD=1).
REQ-018 On expiry with auto_reload=1: COUNT <= LOAD, STATUS.expired <= 1, state remains RUN.
REQ-019 On expiry with auto_reload=0: COUNT <= 0, STATUS.expired <= 1, CTRL.enable <= 0, state <= EXPIRED.
REQ-020 In EXPIRED, COUNT SHALL hold 0. A CTRL write with bit0=1 SHALL behave as in REQ-015.
REQ-021 A CTRL write with bit0=0 in any state SHALL cause a transition to IDLE, hold COUNT, and clear the prescaler.
REQ-022 A CTRL write with bit0=1 while already in RUN SHALL restart: COUNT <= LOAD and prescaler cleared.
REQ-023 A LOAD write SHALL update LOAD only. A running COUNT SHALL be unaffected until the next reload or start.
REQ-024 Simultaneous expiry and STATUS write-1-clear SHALL leave expired=1 (set wins).
REQ-025 Simultaneous expiry and CTRL write SHALL give the CTRL write priority for state, enable and COUNT, while expired is still set.
REQ-026 Writes with addr[15:12]!=BASE SHALL have no effect. Reads of the same cycle's write address SHALL return 0 (no read on write cycles).

Reset
REQ-027 Resetn=0 SHALL immediately force: state IDLE, LOAD=0, COUNT=0, CTRL=0, STATUS=0, prescaler=0, din=0, hit=0, irq=0.
REQ-028 Reset asserted mid-RUN SHALL abort counting with no expiry flag. After release, the block SHALL stay IDLE until enabled.

Verification
REQ-029 Basic one-shot: PRESCALE=4; write LOAD=3, CTRL=1. Required: COUNT reads 3,2,1 and expired=1 exactly 12 cycles after the CTRL write edge; state EXPIRED; CTRL reads 0; COUNT reads 0.
REQ-030 Auto-reload with irq: LOAD=2, CTRL=7. Required: irq rises every 8 cycles; writing STATUS=1 drops irq the next cycle; COUNT reloads to 2 with no gap.
REQ-031 Read timing: read addr 0x3000 after LOAD=0x1234. Required: din=0x1234 and hit=1 one cycle later; read of 0x1000 gives din=0, hit=0.
REQ-032 Collisions: STATUS clear on the expiry cycle leaves expired=1; CTRL=0 on the expiry cycle gives IDLE with COUNT held at 1.
REQ-033 Reset mid-RUN: LOAD=100, enable, assert Resetn low asynchronously between edges. Required: all outputs 0 immediately; after release COUNT stays 0 and never decrements.
REQ-034 Edge values: LOAD=0 expires after one tick. LOAD=0xFFFF decrements to 0xFFFE on the first tick with no wrap. Writing COUNT leaves it unchanged.
